// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one outstanding word access per transaction,
// completed after a fixed programmable latency, with byte-strobed stores and error flagging.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          write_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;
  logic [3:0]    wstrb_r;
  logic [31:0]   rdata_r;
  logic          err_r;
  logic [31:0]   mem_r [DEPTH_WORDS];

  logic          err_s;
  logic          fire_s;
  logic          store_s;
  logic [AW-1:0] idx_s;

  // Decode the held request: error check, word index, and the cycle the access happens
  always_comb begin
    err_s   = (addr_r[1:0] != 2'b00) || (addr_r[31:2] >= DEPTH_L);
    idx_s   = addr_r[AW+1:2];
    fire_s  = (state_r == BUSY) && (cnt_r == 4'd0);
    store_s = fire_s && write_r && !err_s && !reset;
  end

  // Storage: not reset; a store aborted by reset in the access cycle is dropped via store_s
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (store_s && wstrb_r[i]) begin
        mem_r[idx_s][8*i +: 8] <= wdata_r[8*i +: 8];
      end
    end
  end

  // Transaction FSM: capture, latency countdown, access, and held response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      write_r <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
      wstrb_r <= 4'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            write_r <= req_write;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            wstrb_r <= req_wstrb;
            cnt_r   <= CNT_INIT;
            state_r <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            if (err_s) begin
              rdata_r <= 32'd0;
              err_r   <= 1'b1;
            end else if (write_r) begin
              rdata_r <= 32'd0;
              err_r   <= 1'b0;
            end else begin
              rdata_r <= mem_r[idx_s];
              err_r   <= 1'b0;
            end
            state_r <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory-side end of the processor's load/store interface. It accepts one word-addressed read or write per transaction on a valid/ready request channel, performs the access after a fixed programmable latency, and returns the result on a valid/ready response channel. It supports byte strobes for partial stores and flags misaligned or out-of-range accesses. It replaces the zero-latency data memory when the core moves to a handshaked memory bus.

## Interface
Parameters:
- DEPTH_WORDS, 64, number of 32-bit words of storage; legal word index 0..DEPTH_WORDS-1.
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, little-endian byte lanes.
- req_wstrb  input  4  byte-lane write enables; bit i enables req_wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access error (misaligned or out of range).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1, rsp_valid=0. On an edge with req_valid=1, capture write, addr, wdata, wstrb into holding registers, load cnt=LATENCY-1, go to BUSY.
- BUSY: req_ready=0. If cnt!=0, decrement. If cnt==0, perform the access on this edge and go to RESP.
- The access evaluates err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - err=1: no storage change; rsp_rdata<=0, rsp_err<=1.
  - Load, no error: rsp_rdata<=mem[addr[31:2]], rsp_err<=0. Strobes are ignored.
  - Store, no error: for each i with wstrb[i]=1, update byte lane i of mem[addr[31:2]]; other lanes are unchanged. rsp_rdata<=0, rsp_err<=0. wstrb=0000 is legal: no change, normal response.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until the handshake. On an edge with rsp_ready=1, go to IDLE.
- Only one transaction is outstanding. New requests are not accepted in BUSY or RESP, and request inputs are ignored while req_ready=0.
- The holding registers decouple the responder from request inputs after acceptance. Changes to req_* during BUSY have no effect.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0. Storage contents are not affected by reset.
- Acceptance at edge E0 puts rsp_valid high in the cycle following edge E(LATENCY). It is combinationally decoded from state and has no dependence on rsp_ready.
- Responses are registered; no combinational path exists from any input to any output.
- The response handshake at edge Eh returns the FSM to IDLE, so req_ready=1 after Eh. Minimum issue interval is LATENCY+2 cycles (rsp_ready held high).
- rsp_ready low: RESP is held indefinitely, with data and err stable.
- Reset asserted in any state: IDLE on the next edge. An in-flight store not yet performed (state BUSY) is discarded. A store already performed (state RESP) remains in storage. No response is emitted for the aborted transaction.
- Reset takes priority over all handshakes in the same cycle.
- cnt is 4 bits wide and never wraps; it only decrements from LATENCY-1 down to 0.

## Test plan
- Store then load, LATENCY=2:
  - Store addr=0x64, wdata=0x00000080, wstrb=1111 → rsp_valid 2 cycles after acceptance with rsp_err=0, rsp_rdata=0.
  - Load addr=0x64 → rsp_rdata=0x00000080.
- Partial store:
  - Preload word 0x60=0xAABBCCDD.
  - Store wdata=0x11223344, wstrb=0101 → load 0x60 returns 0xAA22CC44.
- Errors:
  - Load addr=0x62 → rsp_err=1, rsp_rdata=0.
  - Store addr=0x100 with DEPTH_WORDS=64 → rsp_err=1, and a following load of 0x0 shows no change.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles → rsp_valid stays 1 with data stable, req_ready stays 0.
  - A new req_valid during this period is not accepted.
  - Raise rsp_ready → IDLE next cycle, and the pending request is accepted then.
- Reset mid-operation:
  - Store 0xDEADBEEF to 0x10 with LATENCY=4, and assert reset 2 cycles after acceptance → no rsp_valid, and a load of 0x10 returns the prior value.
  - Outputs hold their reset values.
- Latency sweep:
  - Run with LATENCY=1 and LATENCY=15 → rsp_valid exactly LATENCY cycles after acceptance.
  - Back-to-back loads with rsp_ready=1 are accepted every LATENCY+2 cycles.
